ps2_keycode_rx: RTL
===================

PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples required to accept a level change.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 50000: clk cycles without a ps2_clk falling edge mid-frame before the frame is abandoned.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ps2_clk, input, 1 bit: keyboard clock, asynchronous to clk.
REQ-006 The block SHALL have port ps2_data, input, 1 bit: keyboard data, asynchronous to clk.
REQ-007 The block SHALL have port keycode, output, 8 bits: the currently held key's scan code, 8'h00 when no key is held.
REQ-008 The block SHALL have port key_valid, output, 1 bit: one-cycle pulse when a make or break event is decoded.
REQ-009 The block SHALL have port key_break, output, 1 bit: qualifies key_valid; 1 means the event is a break (release).
REQ-010 The block SHALL have port key_ext, output, 1 bit: qualifies key_valid; 1 means the code was preceded by E0.
REQ-011 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse when a frame fails the odd-parity check.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; the synchronized ps2_clk SHALL then be glitch-filtered per FILTER_LEN.
REQ-013 A falling edge of the filtered ps2_clk SHALL sample the synchronized ps2_data into an 11-bit frame: start(0), D0..D7 LSB first, odd parity, stop(1).
REQ-014 Frame FSM states SHALL be IDLE, SHIFT and CHECK; IDLE->SHIFT on a falling edge with data=0; a start bit of 1 SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-015 SHIFT->CHECK SHALL occur on the 11th falling edge; CHECK->IDLE SHALL occur on the following clk cycle.
REQ-016 A frame with stop bit 0 SHALL be discarded silently.
REQ-017 In SHIFT, TIMEOUT_CYC cycles without a falling edge SHALL return the FSM to IDLE and discard the partial frame; the timeout counter SHALL be 17 bits, saturating.
REQ-018 A byte of E0 SHALL set a pending-extended flag, and a byte of F0 SHALL set a pending-break flag; neither byte SHALL produce key_valid.
REQ-019 Any other byte SHALL be an event, signalled as follows:
- key_valid=1 in the cycle after CHECK;
- key_ext and key_break driven from the pending flags;
- both pending flags cleared in the same cycle.
REQ-020 A make event SHALL load keycode with the byte; a typematic repeat of the same make SHALL pulse key_valid again with keycode unchanged.
REQ-021 A break event SHALL set keycode to 8'h00 only if the byte equals the current keycode; otherwise keycode SHALL be unchanged.
REQ-022 Latency from the stop-bit falling edge detection to key_valid SHALL be exactly 2 clk cycles.
REQ-023 A timeout or a discarded frame SHALL also clear both pending flags.
REQ-024 key_break and key_ext SHALL be 0 whenever key_valid is 0.

Reset
REQ-025 On rst, the block SHALL force:
- FSM to IDLE;
- shift register, bit counter, timeout counter, filter and both pending flags to 0;
- keycode to 8'h00;
- key_valid, key_break, key_ext and parity_err to 0.
REQ-026 On rst, the synchronizer flops and the filtered ps2_clk SHALL be set to 1 (bus idle high).
REQ-027 Reset asserted mid-frame SHALL abandon the frame, and no event SHALL result from its remaining bits.

Configuration
REQ-028 With PS2_PARITY_CHECK_EN defined, a parity-failing frame SHALL be discarded, pulse parity_err in the cycle after CHECK, and clear both pending flags.
REQ-029 Without PS2_PARITY_CHECK_EN, parity SHALL be ignored and parity_err SHALL be tied to 0.

Structure
REQ-030 The shared package ps2_pkg SHALL hold:
- the frame FSM state enum;
- PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0;
- KEY_UP=8'h75, KEY_DOWN=8'h72, KEY_LEFT=8'h6B, KEY_RIGHT=8'h74.
REQ-031 Synchronizer, filter, frame FSM and timeout SHALL form sub-module ps2_frame_rx, which outputs byte, byte_valid and parity_bad; the E0/F0 decode and keycode hold logic SHALL live in ps2_keycode_rx.

Verification
REQ-032 Frames E0, 75 -> one key_valid with key_ext=1, key_break=0, keycode=8'h75.
REQ-033 Then E0, F0, 75 -> key_valid with key_ext=1, key_break=1, keycode=8'h00.
REQ-034 Make 74, then break F0 6B -> keycode remains 8'h74 and key_valid pulses with key_break=1.
REQ-035 Frame 75 with the parity bit flipped, PS2_PARITY_CHECK_EN defined -> parity_err pulses once, no key_valid, keycode unchanged.
REQ-036 5 bits of a frame, then 50000 idle cycles, then a full frame 72 -> no event from the partial frame; key_valid fires for 72.
REQ-037 rst asserted after the 6th bit of frame 6B, then frame 74 -> keycode=8'h74; no 6B event ever appears.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } frame_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam int unsigned TO_CNT_W  = 17;
    localparam int unsigned BIT_CNT_W = 4;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, ps2_clk glitch filter, frame FSM and timeout.
// Define PS2_PARITY_CHECK_EN to drop odd-parity failures and flag them on o_parity_bad.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_parity_bad,
    output logic       o_frame_drop
);

    localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]           r_clk_sync;
    logic [1:0]           r_data_sync;
    logic                 r_clk_filt;
    logic [FCW-1:0]       r_filt_cnt;
    frame_state_e         r_state;
    frame_state_e         w_next;
    logic [7:0]           r_shift;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [TO_CNT_W-1:0]  r_to_cnt;
    logic [7:0]           r_byte;
    logic                 r_byte_valid;
    logic                 r_parity_bad;
    logic                 r_frame_drop;
    logic                 w_fall;
    logic                 w_data;
    logic                 w_last_edge;
    logic                 w_timeout;
`ifdef PS2_PARITY_CHECK_EN
    logic                 r_par_ok;
`endif

    // Sync both lines; accept a ps2_clk level only after FILTER_LEN agreeing samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_filt  <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FCW'(1);
            end
        end
    end

    assign w_fall = r_clk_filt && !r_clk_sync[1] && (r_filt_cnt == FCW'(FILTER_LEN - 1));
    assign w_data = r_data_sync[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_last_edge = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && !w_data) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_fall) begin
                    if (r_bit_cnt == BIT_CNT_W'(10)) begin
                        w_next      = ST_CHECK;
                        w_last_edge = 1'b1;
                    end
                end else if (r_to_cnt >= TO_CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            ST_CHECK: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Bit 0 is the start bit, 1..8 data LSB first, 9 parity, 10 stop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_to_cnt     <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_parity_bad <= 1'b0;
            r_frame_drop <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_par_ok     <= 1'b0;
`endif
        end else begin
            r_byte_valid <= 1'b0;
            r_parity_bad <= 1'b0;
            r_frame_drop <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= BIT_CNT_W'(1);
                    r_to_cnt  <= '0;
                end
                ST_SHIFT: begin
                    if (w_fall) begin
                        r_to_cnt  <= '0;
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt <= BIT_CNT_W'(8)) r_shift <= {w_data, r_shift[7:1]};
`ifdef PS2_PARITY_CHECK_EN
                        if (r_bit_cnt == BIT_CNT_W'(9)) r_par_ok <= ^{r_shift, w_data};
`endif
                        if (w_last_edge) begin
                            r_byte <= r_shift;
                            if (!w_data) begin
                                r_frame_drop <= 1'b1;
                            end
`ifdef PS2_PARITY_CHECK_EN
                            else if (!r_par_ok) begin
                                r_parity_bad <= 1'b1;
                                r_frame_drop <= 1'b1;
                            end
`endif
                            else begin
                                r_byte_valid <= 1'b1;
                            end
                        end
                    end else if (w_timeout) begin
                        r_frame_drop <= 1'b1;
                    end else if (r_to_cnt != {TO_CNT_W{1'b1}}) begin
                        r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_parity_bad = r_parity_bad;
    assign o_frame_drop = r_frame_drop;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard scan-code decoder: E0/F0 prefix handling and held-key tracking.
// Define PS2_PARITY_CHECK_EN to enable parity checking in the frame receiver.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       key_break,
    output logic       key_ext,
    output logic       parity_err
);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_parity_bad;
    logic       w_frame_drop;
    logic       r_pend_ext;
    logic       r_pend_brk;
    logic [7:0] r_keycode;
    logic       r_key_valid;
    logic       r_key_break;
    logic       r_key_ext;
    logic       r_parity_err;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_parity_bad (w_parity_bad),
        .o_frame_drop (w_frame_drop)
    );

    // Prefix bytes only arm flags; any other byte is an event that consumes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_ext   <= 1'b0;
            r_pend_brk   <= 1'b0;
            r_keycode    <= 8'h00;
            r_key_valid  <= 1'b0;
            r_key_break  <= 1'b0;
            r_key_ext    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_key_valid  <= 1'b0;
            r_key_break  <= 1'b0;
            r_key_ext    <= 1'b0;
            r_parity_err <= w_parity_bad;
            if (w_byte_valid) begin
                if (w_byte == PS2_PREFIX_EXT) begin
                    r_pend_ext <= 1'b1;
                end else if (w_byte == PS2_PREFIX_BRK) begin
                    r_pend_brk <= 1'b1;
                end else begin
                    r_key_valid <= 1'b1;
                    r_key_break <= r_pend_brk;
                    r_key_ext   <= r_pend_ext;
                    r_pend_ext  <= 1'b0;
                    r_pend_brk  <= 1'b0;
                    if (!r_pend_brk)             r_keycode <= w_byte;
                    else if (w_byte == r_keycode) r_keycode <= 8'h00;
                end
            end else if (w_frame_drop) begin
                r_pend_ext <= 1'b0;
                r_pend_brk <= 1'b0;
            end
        end
    end

    assign keycode    = r_keycode;
    assign key_valid  = r_key_valid;
    assign key_break  = r_key_break;
    assign key_ext    = r_key_ext;
    assign parity_err = r_parity_err;

endmodule
